// File: rtl/trb_mem_arbiter.sv
// trb_mem_arbiter
//   Shared trace-buffer RAM below the Logger memory port. A free-running
//   2-bit phase counter time-slices the single-port RAM:
//     phase 0 Logger read, phase 1 Logger write, phase 2 host read,
//     phase 3 host write.
//   The host exchange port performs swaps: it returns the trace word at
//   h_ptr and stores a stream word in its place, then advances h_ptr.
//
// Ports
//   CLK_I, RST_I          clock, synchronous active-high reset
//   RW_TURN_O             high during the Logger write slot (phase 1)
//   WRITE_I/WRITE_PTR_I/DMEM_I   Logger write intent, address, trace word
//   WRITE_ALLOW_O         Logger may write at WRITE_PTR_I (buffer not full)
//   READ_PTR_I/DMEM_O     Logger read address and data (stream word)
//   READ_ALLOW_O          word at READ_PTR_I was swapped in by the host
//   H_REQ_I/H_DATA_I      host swap request (level) and stream word
//   H_DATA_O/H_ACK_O      returned trace word and one-cycle completion pulse
//   H_AVAIL_O/H_PTR_O     unread trace exists, current host pointer

`ifndef TRB_ADDR_WIDTH
`define TRB_ADDR_WIDTH 3
`endif
`ifndef TRB_WIDTH
`define TRB_WIDTH 8
`endif

module trb_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = `TRB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = `TRB_WIDTH
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    output logic                  RW_TURN_O,
    input  logic                  WRITE_I,
    input  logic [ADDR_WIDTH-1:0] WRITE_PTR_I,
    input  logic [DATA_WIDTH-1:0] DMEM_I,
    output logic                  WRITE_ALLOW_O,
    input  logic [ADDR_WIDTH-1:0] READ_PTR_I,
    output logic [DATA_WIDTH-1:0] DMEM_O,
    output logic                  READ_ALLOW_O,
    input  logic                  H_REQ_I,
    input  logic [DATA_WIDTH-1:0] H_DATA_I,
    output logic [DATA_WIDTH-1:0] H_DATA_O,
    output logic                  H_ACK_O,
    output logic                  H_AVAIL_O,
    output logic [ADDR_WIDTH-1:0] H_PTR_O
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_WRITE,
        S_ACK
    } swap_state_t;

    swap_state_t state, state_nxt;

    logic [1:0]            phase;
    logic [ADDR_WIDTH-1:0] h_ptr;
    logic [ADDR_WIDTH-1:0] wr_limit;
    logic [ADDR_WIDTH-1:0] wr_ptr_inc;
    logic [ADDR_WIDTH-1:0] wr_limit_nxt;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_we;
    logic                  write_allow;
    logic                  commit;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] stream_q;
    logic [DATA_WIDTH-1:0] host_rd_q;
    logic [DATA_WIDTH-1:0] h_data_q;
    logic [DATA_WIDTH-1:0] dmem_q;

    // Slot decode and RAM port multiplexing
    always_comb begin
        wr_ptr_inc   = WRITE_PTR_I + 1'b1;
        write_allow  = (wr_ptr_inc != h_ptr);
        commit       = (phase == 2'd1) && WRITE_I && write_allow;
        wr_limit_nxt = commit ? wr_ptr_inc : wr_limit;

        ram_addr = h_ptr;
        case (phase)
            2'd0:    ram_addr = READ_PTR_I;
            2'd1:    ram_addr = WRITE_PTR_I;
            default: ram_addr = h_ptr;
        endcase

        ram_we    = commit || (state == S_WRITE);
        ram_wdata = (state == S_WRITE) ? stream_q : DMEM_I;
    end

    // Swap FSM. The WAIT->READ decision is taken in phase 1 so that READ
    // lands on the phase-2 slot; it looks at the post-commit wr_limit so a
    // Logger write in that same phase 1 is served in the same round.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (H_REQ_I) state_nxt = S_WAIT;
            S_WAIT:  if ((phase == 2'd1) && (wr_limit_nxt != h_ptr)) state_nxt = S_READ;
            S_READ:  state_nxt = S_WRITE;
            S_WRITE: state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            phase     <= '0;
            state     <= S_IDLE;
            h_ptr     <= '0;
            wr_limit  <= '0;
            stream_q  <= '0;
            host_rd_q <= '0;
            h_data_q  <= '0;
            dmem_q    <= '0;
        end else begin
            phase <= phase + 1'b1;
            state <= state_nxt;
            if (commit)
                wr_limit <= wr_ptr_inc;
            if ((state == S_IDLE) && H_REQ_I)
                stream_q <= H_DATA_I;
            if (phase == 2'd0)
                dmem_q <= mem[ram_addr];
            if (state == S_READ)
                host_rd_q <= mem[ram_addr];
            if (state == S_WRITE) begin
                h_data_q <= host_rd_q;
                h_ptr    <= h_ptr + 1'b1;
            end
        end
    end

    // RAM array: contents are not reset
    always_ff @(posedge CLK_I) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
    end

    assign RW_TURN_O     = (phase == 2'd1);
    assign WRITE_ALLOW_O = write_allow;
    assign READ_ALLOW_O  = (READ_PTR_I != h_ptr);
    assign H_AVAIL_O     = (h_ptr != wr_limit);
    assign H_ACK_O       = (state == S_ACK);
    assign H_PTR_O       = h_ptr;
    assign H_DATA_O      = h_data_q;
    assign DMEM_O        = dmem_q;

endmodule

// File: tb/tb_trb_mem_arbiter.sv
// tb_trb_mem_arbiter
//   Self-checking bench for trb_mem_arbiter (ADDR_WIDTH 3, DATA_WIDTH 8).
//   A transaction-level model tracks RAM contents, host pointer and write
//   limit; DUT outputs are compared every cycle on the falling edge.

`timescale 1ns/1ps

module tb_trb_mem_arbiter;

    localparam int unsigned AW    = 3;
    localparam int unsigned DW    = 8;
    localparam int          DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          rw_turn_o;
    logic          write_i;
    logic [AW-1:0] wptr_i;
    logic [DW-1:0] dmem_i;
    logic          write_allow_o;
    logic [AW-1:0] rptr_i;
    logic [DW-1:0] dmem_o;
    logic          read_allow_o;
    logic          h_req_i;
    logic [DW-1:0] h_data_i;
    logic [DW-1:0] h_data_o;
    logic          h_ack_o;
    logic          h_avail_o;
    logic [AW-1:0] h_ptr_o;

    always #5 clk = ~clk;

    trb_mem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .CLK_I        (clk),
        .RST_I        (rst_i),
        .RW_TURN_O    (rw_turn_o),
        .WRITE_I      (write_i),
        .WRITE_PTR_I  (wptr_i),
        .DMEM_I       (dmem_i),
        .WRITE_ALLOW_O(write_allow_o),
        .READ_PTR_I   (rptr_i),
        .DMEM_O       (dmem_o),
        .READ_ALLOW_O (read_allow_o),
        .H_REQ_I      (h_req_i),
        .H_DATA_I     (h_data_i),
        .H_DATA_O     (h_data_o),
        .H_ACK_O      (h_ack_o),
        .H_AVAIL_O    (h_avail_o),
        .H_PTR_O      (h_ptr_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_valid [DEPTH];
    int            m_hptr;
    int            m_wrlim;
    int            ph;
    int            lp;
    logic [DW-1:0] m_hdata;
    bit            m_hdata_ok;
    logic [DW-1:0] exp_dmem;
    bit            exp_dmem_ok;
    bit            req_pend;
    logic [DW-1:0] req_data;
    int            wait_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_hptr      = 0;
        m_wrlim     = 0;
        ph          = 0;
        lp          = 0;
        m_hdata     = '0;
        m_hdata_ok  = 1'b1;
        exp_dmem_ok = 1'b0;
        req_pend    = 1'b0;
        wait_cnt    = 0;
    endtask

    task automatic do_reset();
        rst_i   = 1'b1;
        write_i = 1'b0;
        h_req_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();
    endtask

    // One clock cycle: check outputs mid-cycle, apply the model's view of
    // what commits at the coming rising edge, then step past that edge.
    task automatic cycle();
        @(negedge clk);
        if (req_pend && (m_hptr != m_wrlim)) wait_cnt++;
        if (h_ack_o) begin
            check_eq("ack_pending", 32'(req_pend), 1);
            check_eq("ack_phase", ph, 0);
            check_eq("ack_latency", 32'(wait_cnt <= 8), 1);
            m_hdata_ok      = m_valid[m_hptr];
            m_hdata         = m_mem[m_hptr];
            m_mem[m_hptr]   = req_data;
            m_valid[m_hptr] = 1'b1;
            m_hptr          = (m_hptr + 1) % DEPTH;
            req_pend        = 1'b0;
            h_req_i         = 1'b0;
            wait_cnt        = 0;
        end
        check_eq("rw_turn", 32'(rw_turn_o), 32'(ph == 1));
        check_eq("h_ptr", 32'(h_ptr_o), m_hptr);
        check_eq("h_avail", 32'(h_avail_o), 32'(m_hptr != m_wrlim));
        check_eq("write_allow", 32'(write_allow_o), 32'(((int'(wptr_i) + 1) % DEPTH) != m_hptr));
        check_eq("read_allow", 32'(read_allow_o), 32'(int'(rptr_i) != m_hptr));
        if (m_hdata_ok) check_eq("h_data", 32'(h_data_o), 32'(m_hdata));
        if ((ph != 0) && exp_dmem_ok) check_eq("dmem", 32'(dmem_o), 32'(exp_dmem));
        if (ph == 0) begin
            exp_dmem_ok = m_valid[rptr_i];
            exp_dmem    = m_mem[rptr_i];
        end
        if ((ph == 1) && write_i && (((int'(wptr_i) + 1) % DEPTH) != m_hptr)) begin
            m_mem[wptr_i]   = dmem_i;
            m_valid[wptr_i] = 1'b1;
            m_wrlim         = (int'(wptr_i) + 1) % DEPTH;
            lp              = m_wrlim;
        end
        @(posedge clk);
        #1;
        ph = (ph + 1) % 4;
    endtask

    task automatic logger_write(input int ptr, input logic [DW-1:0] data);
        write_i = 1'b0;
        wptr_i  = AW'(ptr);
        dmem_i  = data;
        while (ph != 1) cycle();
        write_i = 1'b1;
        cycle();
        write_i = 1'b0;
    endtask

    task automatic raise_req(input logic [DW-1:0] data);
        h_req_i  = 1'b1;
        h_data_i = data;
        req_pend = 1'b1;
        req_data = data;
        wait_cnt = 0;
    endtask

    task automatic host_request(input logic [DW-1:0] data);
        raise_req(data);
        for (int k = 0; k < 40 && req_pend; k++) cycle();
        check_eq("ack_seen", 32'(req_pend), 0);
        h_req_i  = 1'b0;
        req_pend = 1'b0;
    endtask

    initial begin
        rst_i    = 1'b1;
        write_i  = 1'b0;
        wptr_i   = '0;
        dmem_i   = '0;
        rptr_i   = '0;
        h_req_i  = 1'b0;
        h_data_i = '0;
        model_reset();
        do_reset();

        // Reset values and RW_TURN pattern
        check_eq("rst_dmem", 32'(dmem_o), 0);
        check_eq("rst_h_data", 32'(h_data_o), 0);
        check_eq("rst_ack", 32'(h_ack_o), 0);
        check_eq("rst_write_allow", 32'(write_allow_o), 1);
        check_eq("rst_read_allow", 32'(read_allow_o), 0);
        repeat (4) cycle();

        // Off-slot writes are ignored
        repeat (8) begin
            write_i = (ph != 1);
            wptr_i  = AW'($urandom_range(0, 7));
            dmem_i  = DW'($urandom);
            cycle();
        end
        write_i = 1'b0;
        check_eq("offslot_avail", 32'(h_avail_o), 0);

        // Single swap
        wptr_i = '0;
        rptr_i = '0;
        logger_write(0, 8'hA5);
        host_request(8'h3C);
        check_eq("swap_h_data", 32'(h_data_o), 32'h A5);
        check_eq("swap_h_ptr", 32'(h_ptr_o), 1);
        repeat (4) cycle();
        check_eq("swap_read_allow", 32'(read_allow_o), 1);
        check_eq("swap_dmem", 32'(dmem_o), 32'h3C);

        // Full buffer
        do_reset();
        for (int p = 0; p < 7; p++) logger_write(p, DW'(8'h10 + p));
        logger_write(7, 8'hEE);
        check_eq("full_avail", 32'(h_avail_o), 1);
        for (int p = 0; p < 7; p++) begin
            host_request(DW'($urandom));
            check_eq("full_drain", 32'(h_data_o), 32'(8'h10 + p));
        end
        check_eq("full_limit", 32'(h_avail_o), 0);

        // Wrap-around
        do_reset();
        for (int i = 0; i < 20; i++) begin
            logger_write(i % DEPTH, DW'(i));
            host_request(DW'($urandom));
            check_eq("wrap_data", 32'(h_data_o), i);
        end

        // Reset in the WRITE state of a swap
        logger_write(lp, 8'h77);
        raise_req(8'h55);
        repeat (5) cycle();
        rst_i = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_noack_w", 32'(h_ack_o), 0);
        @(posedge clk);
        #1;
        rst_i   = 1'b0;
        h_req_i = 1'b0;
        model_reset();
        check_eq("mid_rst_h_ptr", 32'(h_ptr_o), 0);
        check_eq("mid_rst_ack", 32'(h_ack_o), 0);
        repeat (4) cycle();

        // Randomized traffic
        do_reset();
        repeat (400) begin
            write_i = 1'($urandom_range(0, 1));
            wptr_i  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 7)) : AW'(lp);
            dmem_i  = DW'($urandom);
            rptr_i  = AW'($urandom_range(0, 7));
            if (!req_pend && ($urandom_range(0, 3) == 0)) raise_req(DW'($urandom));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
